// File: rtl/dac_sample_sequencer.sv
// ============================================================================
//  Module      : dac_sample_sequencer
//  Description : Sample FIFO plus rate divider that paces core samples to the
//                DAC, with priming, underflow hold and enable sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_sample_sequencer #(
   parameter int DW        = 10,
   parameter int DEPTH     = 8,
   parameter int DIVW      = 16,
   parameter int PRIME_LVL = 4,
   parameter int MIDSCALE  = 512
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [DIVW-1:0]          rate_div,
   input  logic [DW-1:0]            in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DW-1:0]            D,
   output logic                     sample_tick,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     underflow,
   input  logic                     clr_underflow,
   output logic [1:0]               state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t          state_q;
   logic [DIVW-1:0] cnt_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [LW-1:0]   level_q;
   logic [LW-1:0]   level_d;
   logic [DW-1:0]   d_q;
   logic            tick_q;
   logic            uf_q;
   logic [DW-1:0]   mem_q [DEPTH];

   logic push_w;
   logic slot_w;
   logic pop_w;
   logic uf_set_w;

   assign in_ready = (level_q != LW'(DEPTH));
   assign push_w   = in_valid && in_ready;
   assign slot_w   = (state_q == ST_RUN) && (cnt_q == '0);
   // A disable on a slot edge wins: neither pop nor underflow happens there.
   assign pop_w    = slot_w && enable && (level_q != '0);
   assign uf_set_w = slot_w && enable && (level_q == '0);

   always_comb begin
      level_d = level_q;
      case ({push_w, pop_w})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (push_w && !reset) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         d_q      <= DW'(MIDSCALE);
         tick_q   <= 1'b0;
         uf_q     <= 1'b0;
      end else begin
         tick_q  <= pop_w;
         level_q <= level_d;
         if (push_w) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            d_q      <= mem_q[rd_ptr_q];
         end
         if (uf_set_w) begin
            uf_q <= 1'b1;
         end else if (clr_underflow) begin
            uf_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (enable) state_q <= ST_PRIME;
            end
            ST_PRIME: begin
               cnt_q <= '0;
               if (!enable) begin
                  state_q <= ST_IDLE;
               end else if (level_q >= LW'(PRIME_LVL)) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (slot_w) begin
                  if (level_q == '0) begin
                     state_q <= ST_PRIME;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= rate_div;
                  end
               end else begin
                  cnt_q <= cnt_q - DIVW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign D           = d_q;
   assign sample_tick = tick_q;
   assign level       = level_q;
   assign underflow   = uf_q;
   assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_sample_sequencer.sv
// ============================================================================
//  Module      : tb_dac_sample_sequencer
//  Description : Directed vector table plus hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_sample_sequencer;

   localparam int DW   = 10;
   localparam int DIVW = 16;

   logic            CLK = 1'b0;
   logic            reset = 1'b0;
   logic            enable = 1'b0;
   logic [DIVW-1:0] rate_div = '0;
   logic [DW-1:0]   in_data = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW-1:0]   D;
   logic            sample_tick;
   logic [3:0]      level;
   logic            underflow;
   logic            clr_underflow = 1'b0;
   logic [1:0]      state;

   int checks   = 0;
   int failures = 0;

   dac_sample_sequencer #(
      .DW(10), .DEPTH(8), .DIVW(16), .PRIME_LVL(4), .MIDSCALE(512)
   ) dut (
      .CLK(CLK), .reset(reset), .enable(enable), .rate_div(rate_div),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .D(D), .sample_tick(sample_tick), .level(level),
      .underflow(underflow), .clr_underflow(clr_underflow), .state(state)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic            rst, en, vld, clr;
      logic [DW-1:0]   din;
      logic [DIVW-1:0] rdiv;
      int              exp_d, exp_tick, exp_level, exp_state, exp_uf, exp_rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, en, vld, clr, input int din, rdiv,
                               input int d, tick, lvl, st, uf, rdy);
      vec_t v;
      v.rst = rst; v.en = en; v.vld = vld; v.clr = clr;
      v.din = DW'(din); v.rdiv = DIVW'(rdiv);
      v.exp_d = d; v.exp_tick = tick; v.exp_level = lvl;
      v.exp_state = st; v.exp_uf = uf; v.exp_rdy = rdy;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int d, tick, lvl, st, uf, rdy);
      check({tag, ".D"}, int'(D), d);
      check({tag, ".tick"}, int'(sample_tick), tick);
      check({tag, ".level"}, int'(level), lvl);
      check({tag, ".state"}, int'(state), st);
      check({tag, ".underflow"}, int'(underflow), uf);
      check({tag, ".in_ready"}, int'(in_ready), rdy);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Reset with valid asserted, prefill 1..5, prime, then play at period 4.
      vecs.push_back(mk(1, 0, 1, 0, 7, 3, 512, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 1, 0, 7, 3, 512, 0, 0, 0, 0, 1));
      for (int k = 1; k <= 5; k++)
         vecs.push_back(mk(0, 0, 1, 0, k, 3, 512, 0, k, 0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 3, 512, 0, 5, 1, 0, 1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 3, 512, 0, 5, 2, 0, 1));
      for (int k = 1; k <= 5; k++) begin
         vecs.push_back(mk(0, 1, 0, 0, 0, 3, k, 1, 5 - k, 2, 0, 1));
         for (int j = 0; j < 3; j++)
            vecs.push_back(mk(0, 1, 0, 0, 0, 3, k, 0, 5 - k, 2, 0, 1));
      end
      vecs.push_back(mk(0, 1, 0, 0, 0, 3, 5, 0, 0, 1, 1, 1));
      vecs.push_back(mk(0, 1, 0, 1, 0, 3, 5, 0, 0, 1, 0, 1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 3, 5, 0, 0, 1, 0, 1));

      #1;
      foreach (vecs[i]) begin
         reset = vecs[i].rst; enable = vecs[i].en; in_valid = vecs[i].vld;
         clr_underflow = vecs[i].clr; in_data = vecs[i].din; rate_div = vecs[i].rdiv;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_tick,
                   vecs[i].exp_level, vecs[i].exp_state, vecs[i].exp_uf, vecs[i].exp_rdy);
      end
      in_valid = 1'b0; clr_underflow = 1'b0;

      // Backpressure: fill to DEPTH while idle, then drain one per cycle.
      enable = 1'b0;
      step();
      check("bp.idle", int'(state), 0);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = DW'(100 + i);
         check("bp.ready", int'(in_ready), 1);
         step();
         check("bp.level", int'(level), i + 1);
      end
      in_data = DW'(108);
      check("bp.full_ready", int'(in_ready), 0);
      step();
      check("bp.full_level", int'(level), 8);
      in_valid = 1'b0;
      rate_div = '0; enable = 1'b1;
      step();
      check("bp.prime", int'(state), 1);
      step();
      check_all("bp.run", 5, 0, 8, 2, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         check_all($sformatf("bp.pop%0d", i), 100 + i, 1, 7 - i, 2, 0, 1);
      end
      step();
      check_all("bp.uf", 107, 0, 0, 1, 1, 1);
      clr_underflow = 1'b1;
      step();
      clr_underflow = 1'b0;
      check("bp.clr", int'(underflow), 0);

      // Disable exactly on a slot edge, then re-prime.
      rate_div = DIVW'(2); enable = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = DW'(200 + i);
         step();
      end
      in_valid = 1'b0;
      check_all("dis.fill", 107, 0, 4, 0, 0, 1);
      enable = 1'b1;
      step();
      check("dis.prime", int'(state), 1);
      step();
      check("dis.run", int'(state), 2);
      step();
      check_all("dis.pop", 200, 1, 3, 2, 0, 1);
      step();
      step();
      check_all("dis.preslot", 200, 0, 3, 2, 0, 1);
      enable = 1'b0;
      step();
      check_all("dis.off", 200, 0, 3, 0, 0, 1);
      enable = 1'b1;
      step();
      check("dis.reprime", int'(state), 1);
      in_valid = 1'b1; in_data = DW'(204);
      step();
      in_valid = 1'b0;
      check_all("dis.lvl4", 200, 0, 4, 1, 0, 1);
      step();
      check("dis.rerun", int'(state), 2);
      step();
      check_all("dis.pop2", 201, 1, 3, 2, 0, 1);

      // Reset while running with five entries queued.
      in_valid = 1'b1; in_data = DW'(205);
      step();
      in_data = DW'(206);
      step();
      in_valid = 1'b0;
      check_all("rst.pre", 201, 0, 5, 2, 0, 1);
      enable = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      check_all("rst.post", 512, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = DW'(300 + i);
         step();
      end
      in_valid = 1'b0;
      enable = 1'b1;
      step();
      step();
      check("rst.run", int'(state), 2);
      step();
      check_all("rst.pop", 300, 1, 3, 2, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
